// File: rtl/fft_meas_seq_if.sv
// FFT-side handshake bundle for the measurement sequencer: config and data AXI-Stream,
// FFT reset, and the RAM-write / frequency-analysis handshake.
interface fft_meas_seq_if;
    logic       cfg_tready;
    logic       cfg_tvalid;
    logic [7:0] cfg_tdata;
    logic       fft_aresetn;
    logic       dat_tready;
    logic       dat_tvalid;
    logic       dat_tlast;
    logic       wr_done;
    logic       freq_valid;
    logic       ana_en;

    modport master (
        input  cfg_tready, dat_tready, wr_done, freq_valid,
        output cfg_tvalid, cfg_tdata, fft_aresetn, dat_tvalid, dat_tlast, ana_en
    );

    modport slave (
        output cfg_tready, dat_tready, wr_done, freq_valid,
        input  cfg_tvalid, cfg_tdata, fft_aresetn, dat_tvalid, dat_tlast, ana_en
    );
endinterface

// File: rtl/fft_meas_seq.sv
// Measurement sequencer: key start -> FFT reset/config -> stream N_PTS samples ->
// wait for modulus RAM write -> trigger frequency analysis, with a per-phase watchdog.
module fft_meas_seq #(
    parameter int unsigned N_PTS    = 1024,
    parameter int unsigned RST_CYC  = 4,
    parameter logic [7:0]  CFG_WORD = 8'h01,
    parameter int unsigned TMO_CYC  = 1048576,
    parameter bit          CONT     = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key,
    fft_meas_seq_if.master fft,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [2:0]    state_o
);

    localparam int unsigned BEAT_W  = $clog2(N_PTS);
    localparam int unsigned TMR_MAX = (TMO_CYC > RST_CYC) ? TMO_CYC : RST_CYC;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_PTS - 1);
    localparam logic [TMR_W-1:0]  RST_END   = TMR_W'(RST_CYC - 1);
    localparam logic [TMR_W-1:0]  TMO_END   = TMR_W'(TMO_CYC - 1);
    localparam logic [TMR_W-1:0]  TMR_SAT   = TMR_W'(TMR_MAX);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RST  = 3'd1,
        S_CFG  = 3'd2,
        S_FEED = 3'd3,
        S_WWR  = 3'd4,
        S_ANA  = 3'd5,
        S_DONE = 3'd6,
        S_ERR  = 3'd7
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          key_sync;
    logic                key_q;
    logic                start_c;
    logic [BEAT_W-1:0]   beat;
    logic [BEAT_W-1:0]   beat_nxt;
    logic [TMR_W-1:0]    tmr;
    logic                tmo_c;
    logic                beat_acc_c;

    // Key synchroniser plus falling-edge detect on the synchronised level
    always_ff @(posedge clk) begin
        if (rst) begin
            key_sync <= 2'b11;
            key_q    <= 1'b1;
        end else begin
            key_sync <= {key_sync[0], key};
            key_q    <= key_sync[1];
        end
    end

    assign start_c    = key_q & ~key_sync[1];
    assign tmo_c      = (tmr == TMO_END);
    assign beat_acc_c = fft.dat_tvalid & fft.dat_tready;

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        case (state)
            S_IDLE: if (start_c) state_nxt = S_RST;
            S_RST:  if (tmr == RST_END) state_nxt = S_CFG;
            S_CFG: begin
                if (fft.cfg_tvalid && fft.cfg_tready) state_nxt = S_FEED;
                else if (tmo_c)                        state_nxt = S_ERR;
            end
            S_FEED: begin
                if (beat_acc_c) begin
                    if (beat == LAST_BEAT) state_nxt = S_WWR;
                    else                   beat_nxt  = beat + 1'b1;
                end else if (tmo_c) begin
                    state_nxt = S_ERR;
                end
            end
            S_WWR: begin
                if (fft.wr_done) state_nxt = S_ANA;
                else if (tmo_c)  state_nxt = S_ERR;
            end
            // freq_valid coinciding with the ana_en pulse is stale and must not complete the run
            S_ANA: begin
                if (fft.freq_valid && !fft.ana_en) state_nxt = S_DONE;
                else if (tmo_c)                    state_nxt = S_ERR;
            end
            S_DONE: begin
                if (CONT) state_nxt = start_c ? S_IDLE : S_RST;
                else if (start_c) state_nxt = S_RST;
            end
            S_ERR:  if (start_c) state_nxt = S_RST;
            default: state_nxt = S_IDLE;
        endcase
        if (state_nxt != S_FEED) beat_nxt = '0;
    end

    // State, counters and outputs; outputs are decoded from the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            beat            <= '0;
            tmr             <= '0;
            fft.fft_aresetn <= 1'b0;
            fft.cfg_tvalid  <= 1'b0;
            fft.dat_tvalid  <= 1'b0;
            fft.dat_tlast   <= 1'b0;
            fft.ana_en      <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            if (state_nxt != state)  tmr <= '0;
            else if (tmr != TMR_SAT) tmr <= tmr + 1'b1;
            fft.fft_aresetn <= (state_nxt inside {S_CFG, S_FEED, S_WWR, S_ANA});
            fft.cfg_tvalid  <= (state_nxt == S_CFG);
            fft.dat_tvalid  <= (state_nxt == S_FEED);
            fft.dat_tlast   <= (state_nxt == S_FEED) && (beat_nxt == LAST_BEAT);
            fft.ana_en      <= (state == S_WWR) && (state_nxt == S_ANA);
            busy            <= (state_nxt inside {S_RST, S_CFG, S_FEED, S_WWR, S_ANA});
            done            <= (state_nxt == S_DONE);
            err             <= (state_nxt == S_ERR);
        end
    end

    assign state_o       = 3'(state);
    assign fft.cfg_tdata = CFG_WORD;

endmodule
